// File: rtl/inst_mem_loader_pkg.sv
// inst_loader_pkg: shared FSM state type and stream framing constants for the instruction loader.
package inst_loader_pkg;
  typedef enum logic [2:0] {IDLE, HDR, LOAD, WRITE, DONE, ERR} state_t;
  localparam int HDR_BYTES = 4;
  localparam int WORD_BYTES = 4;
endpackage

// File: rtl/inst_mem_loader_if.sv
// inst_mem_loader_if: control, byte stream and instruction-memory write port of the loader.
interface inst_mem_loader_if #(parameter int CNT_W = 9);
  logic start;
  logic s_valid;
  logic [7:0] s_byte;
  logic s_ready;
  logic mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic busy;
  logic done;
  logic err;
  logic [CNT_W-1:0] word_cnt;
  modport slave (
    input start, s_valid, s_byte,
    output s_ready, mem_we, mem_addr, mem_wdata, busy, done, err, word_cnt
  );
  modport master (
    output start, s_valid, s_byte,
    input s_ready, mem_we, mem_addr, mem_wdata, busy, done, err, word_cnt
  );
endinterface

// File: rtl/inst_mem_loader_byte_packer.sv
// byte_packer: assembles little-endian 32-bit words from a byte stream.
// word_full/word_out are valid combinationally on the cycle the last byte is accepted.
module byte_packer
  import inst_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_out,
  output logic        word_full
);
  logic [1:0] r_lane;
  logic [23:0] r_lo;
  assign word_full = byte_en && (r_lane == 2'(WORD_BYTES - 1));
  assign word_out = {byte_in, r_lo};
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_lane <= '0;
      r_lo <= '0;
    end else if (byte_en) begin
      r_lane <= r_lane + 2'd1;
      if (!word_full) r_lo[{r_lane, 3'b000} +: 8] <= byte_in;
    end
  end
endmodule

// File: rtl/inst_mem_loader.sv
// inst_mem_loader: loads a length-prefixed byte stream into instruction memory,
// one word write per packed instruction, holding the core off while busy.
module inst_mem_loader
  import inst_loader_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int CNT_W = $clog2(DEPTH_WORDS) + 1
) (
  input logic clk,
  input logic rst,
  inst_mem_loader_if.slave bus
);
  state_t r_state;
  logic r_ready, r_we, r_busy, r_done, r_err;
  logic [31:0] r_addr, r_wdata, r_len;
  logic [CNT_W-1:0] r_cnt;
  logic w_start, w_full;
  logic [31:0] w_word, w_cnt_next;
  assign w_start = bus.start && (r_state == IDLE || r_state == DONE || r_state == ERR);
  assign w_cnt_next = 32'(r_cnt) + 32'd1;
  byte_packer u_packer (
    .clk(clk),
    .rst(rst),
    .clear(w_start),
    .byte_en(bus.s_valid && r_ready),
    .byte_in(bus.s_byte),
    .word_out(w_word),
    .word_full(w_full)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ready <= 1'b0;
      r_we <= 1'b0;
      r_addr <= BASE_ADDR;
      r_wdata <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err <= 1'b0;
      r_cnt <= '0;
      r_len <= '0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        IDLE, DONE, ERR: if (w_start) begin
          r_state <= HDR;
          r_ready <= 1'b1;
          r_busy <= 1'b1;
          r_done <= 1'b0;
          r_err <= 1'b0;
          r_cnt <= '0;
        end
        HDR: if (w_full) begin
          r_len <= w_word;
          r_state <= (w_word == 32'd0) ? DONE : (w_word > 32'(DEPTH_WORDS)) ? ERR : LOAD;
          r_ready <= (w_word != 32'd0) && (w_word <= 32'(DEPTH_WORDS));
          r_busy <= (w_word != 32'd0) && (w_word <= 32'(DEPTH_WORDS));
          r_done <= (w_word == 32'd0) || (w_word > 32'(DEPTH_WORDS));
          r_err <= w_word > 32'(DEPTH_WORDS);
        end
        LOAD: if (w_full) begin
          r_state <= WRITE;
          r_ready <= 1'b0;
          r_we <= 1'b1;
          r_wdata <= w_word;
          r_addr <= BASE_ADDR + 32'(WORD_BYTES) * 32'(r_cnt);
        end
        WRITE: begin
          r_cnt <= r_cnt + CNT_W'(1);
          r_state <= (w_cnt_next == r_len) ? DONE : LOAD;
          r_ready <= w_cnt_next != r_len;
          r_busy <= w_cnt_next != r_len;
          r_done <= w_cnt_next == r_len;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign bus.s_ready = r_ready;
  assign bus.mem_we = r_we;
  assign bus.mem_addr = r_addr;
  assign bus.mem_wdata = r_wdata;
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.err = r_err;
  assign bus.word_cnt = r_cnt;
endmodule
